// File: rtl/systolic_tile_sched_pkg.sv
// Shared types and constants for the systolic GEMM tile scheduler.
// Holds the FSM state encoding, request-select codes and the latched job configuration.
package systolic_tile_sched_pkg;

  localparam int SCHED_CNT_W = 16;
  localparam int SCHED_KT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_C     = 3'd1,
    ST_LOAD_A     = 3'd2,
    ST_LOAD_B     = 3'd3,
    ST_SYSTOLIC   = 3'd4,
    ST_ACCUM      = 3'd5,
    ST_WRITE_BACK = 3'd6,
    ST_FINISH     = 3'd7
  } sched_state_t;

  localparam logic [3:0] SEL_C  = 4'b0001;
  localparam logic [3:0] SEL_A  = 4'b0010;
  localparam logic [3:0] SEL_B  = 4'b0100;
  localparam logic [3:0] SEL_WB = 4'b1000;

  typedef struct packed {
    logic [SCHED_KT_W-1:0]  k_tiles;
    logic [SCHED_CNT_W-1:0] sys_cyc;
    logic [SCHED_CNT_W-1:0] acc_cyc;
    logic                   c_zero;
  } sched_cfg_t;

endpackage

// File: rtl/systolic_tile_sched_phase_counter.sv
// Down-counter for the timed SYSTOLIC / ACCUM phases: loadable, enable-gated, never wraps below zero.
module systolic_tile_sched_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile scheduler for the systolic GEMM array: C preload/zero-init, K rounds of A/B fetch and
// systolic flow, accumulate, then C write-back, with a held valid/ready request to the memory side.
module systolic_tile_sched
  import systolic_tile_sched_pkg::*;
#(
  parameter int CNT_W = SCHED_CNT_W,
  parameter int KT_W  = SCHED_KT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [KT_W-1:0]  cfg_k_tiles,
  input  logic [CNT_W-1:0] cfg_sys_cyc,
  input  logic [CNT_W-1:0] cfg_acc_cyc,
  input  logic            cfg_c_zero,
  input  logic            stall,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [3:0]      req_sel,
  output logic [KT_W-1:0]  req_tile,
  input  logic            mem_done,
  output logic            pe_flow,
  output logic            pe_accum,
  output logic            pe_clear,
  output logic            busy,
  output logic            done
);

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  function automatic logic [KT_W-1:0] clamp_kt(input logic [KT_W-1:0] v);
    return (v == '0) ? KT_W'(1) : v;
  endfunction

  sched_state_t     state_q, state_d;
  sched_cfg_t       cfg_q;
  logic [KT_W-1:0]  k_idx_q;
  logic             acc_q;
  logic             entry_q;

  logic             cfg_latch;
  logic             k_inc;
  logic             xfer_ok;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;
  logic [KT_W-1:0]  k_last;
  logic [CNT_W-1:0] sys_cyc;
  logic [CNT_W-1:0] acc_cyc;

  assign sys_cyc = CNT_W'(cfg_q.sys_cyc);
  assign acc_cyc = CNT_W'(cfg_q.acc_cyc);
  assign k_last  = KT_W'(cfg_q.k_tiles) - KT_W'(1);

  systolic_tile_sched_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cfg_latch    = 1'b0;
    k_inc        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    req_valid    = 1'b0;
    req_sel      = 4'b0000;
    req_tile     = '0;
    pe_flow      = 1'b0;
    pe_accum     = 1'b0;
    done         = 1'b0;
    busy         = (state_q != ST_IDLE);
    // A transfer only completes once its request has been accepted.
    xfer_ok      = acc_q && mem_done;
    pe_clear     = entry_q && (state_q == ST_LOAD_A) && (k_idx_q == '0) && cfg_q.c_zero;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_latch = 1'b1;
          state_d   = cfg_c_zero ? ST_LOAD_A : ST_LOAD_C;
        end
      end
      ST_LOAD_C: begin
        req_valid = !acc_q;
        req_sel   = SEL_C;
        if (xfer_ok) state_d = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        req_valid = !acc_q;
        req_sel   = SEL_A;
        req_tile  = k_idx_q;
        if (xfer_ok) state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        req_valid = !acc_q;
        req_sel   = SEL_B;
        req_tile  = k_idx_q;
        if (xfer_ok) begin
          state_d      = ST_SYSTOLIC;
          cnt_load     = 1'b1;
          cnt_load_val = sys_cyc - CNT_W'(1);
        end
      end
      ST_SYSTOLIC: begin
        // Whole-array flow or hold; the count advances only on flowing cycles.
        pe_flow = !stall;
        cnt_en  = !stall;
        if (cnt_zero && !stall) begin
          if (k_idx_q < k_last) begin
            k_inc   = 1'b1;
            state_d = ST_LOAD_A;
          end else begin
            state_d      = ST_ACCUM;
            cnt_load     = 1'b1;
            cnt_load_val = acc_cyc - CNT_W'(1);
          end
        end
      end
      ST_ACCUM: begin
        pe_accum = 1'b1;
        cnt_en   = 1'b1;
        if (cnt_zero) state_d = ST_WRITE_BACK;
      end
      ST_WRITE_BACK: begin
        req_valid = !acc_q;
        req_sel   = SEL_WB;
        if (xfer_ok) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!req_valid) begin
      req_sel  = 4'b0000;
      req_tile = '0;
    end

    if (abort) begin
      state_d   = ST_IDLE;
      cfg_latch = 1'b0;
      k_inc     = 1'b0;
      cnt_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_latch) begin
      cfg_q.k_tiles <= SCHED_KT_W'(clamp_kt(cfg_k_tiles));
      cfg_q.sys_cyc <= SCHED_CNT_W'(clamp_cnt(cfg_sys_cyc));
      cfg_q.acc_cyc <= SCHED_CNT_W'(clamp_cnt(cfg_acc_cyc));
      cfg_q.c_zero  <= cfg_c_zero;
    end
    if (!rst) begin
      state_q <= ST_IDLE;
      k_idx_q <= '0;
      acc_q   <= 1'b0;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      if ((state_d != state_q) || abort) begin
        acc_q <= 1'b0;
      end else if (req_valid && req_ready) begin
        acc_q <= 1'b1;
      end
      if (abort || cfg_latch) begin
        k_idx_q <= '0;
      end else if (k_inc) begin
        k_idx_q <= k_idx_q + KT_W'(1);
      end
    end
  end

endmodule
